// File: rtl/truth_table_capture.sv
// Walks a DUT input vector through every combination, lets it settle, samples z_in and
// assembles the truth table. Optional comparison against an expected table: TT_COMPARE_EN.
module truth_table_capture #(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 z_in,
`ifdef TT_COMPARE_EN
    input  logic [2**N_IN-1:0]   expected,
    output logic                 mismatch,
`endif
    output logic [N_IN-1:0]      stim,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 busy,
    output logic                 done,
    output logic                 valid
);

    localparam int TW = 2**N_IN;
    localparam int IW = N_IN + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(TW - 1);
    localparam logic [7:0]    SETTLE   = 8'(SETTLE_CYCLES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_APPLY  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [TW-1:0]   table_q, table_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            valid_q, valid_d;
    logic            mismatch_q, mismatch_d;

    // Next-state and next-output logic for the capture sequencer.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        stim_d     = stim_q;
        table_d    = table_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        mismatch_d = mismatch_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_APPLY;
                    idx_d      = {IW{1'b0}};
                    cnt_d      = 8'd0;
                    stim_d     = {N_IN{1'b0}};
                    table_d    = {TW{1'b0}};
                    busy_d     = 1'b1;
                    valid_d    = 1'b0;
                    mismatch_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                cnt_d = cnt_q + 8'd1;
                if ((cnt_q + 8'd1) == SETTLE) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_APPLY;
                end
            end
            ST_SAMPLE: begin
                // z_in is only ever looked at here, so settle-time glitches never reach the table.
                table_d[idx_q[N_IN-1:0]] = z_in;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_APPLY;
                    idx_d   = idx_q + IW'(1);
                    stim_d  = idx_q[N_IN-1:0] + N_IN'(1);
                    cnt_d   = 8'd0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                stim_d  = {N_IN{1'b0}};
`ifdef TT_COMPARE_EN
                mismatch_d = (table_q != expected);
`else
                mismatch_d = 1'b0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                stim_d  = {N_IN{1'b0}};
            end
        endcase
    end

    // State and output registers; reset drops any partial table immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= {IW{1'b0}};
            cnt_q      <= 8'd0;
            stim_q     <= {N_IN{1'b0}};
            table_q    <= {TW{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            stim_q     <= stim_d;
            table_q    <= table_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign stim      = stim_q;
    assign table_out = table_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign valid     = valid_q;
`ifdef TT_COMPARE_EN
    assign mismatch  = mismatch_q;
`else
    logic unused_mismatch_s;
    assign unused_mismatch_s = mismatch_q;
`endif

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: default instance (SETTLE_CYCLES=2) and a SETTLE_CYCLES=3 instance,
// each driven by a small combinational stand-in DUT selected by a function code.
module tb_truth_table_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start_a, start_b, glitch_a;
    logic [2:0] code_a, code_b;
    logic       z_a, z_b;
    logic [1:0] stim_a, stim_b;
    logic [3:0] tbl_a, tbl_b;
    logic       busy_a, busy_b, done_a, done_b, valid_a, valid_b;
`ifdef TT_COMPARE_EN
    logic [3:0] exp_a, exp_b;
    logic       mm_a, mm_b;
`endif

    truth_table_capture #(.N_IN(2), .SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .z_in(z_a),
`ifdef TT_COMPARE_EN
        .expected(exp_a), .mismatch(mm_a),
`endif
        .stim(stim_a), .table_out(tbl_a), .busy(busy_a), .done(done_a), .valid(valid_a)
    );

    truth_table_capture #(.N_IN(2), .SETTLE_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .z_in(z_b),
`ifdef TT_COMPARE_EN
        .expected(exp_b), .mismatch(mm_b),
`endif
        .stim(stim_b), .table_out(tbl_b), .busy(busy_b), .done(done_b), .valid(valid_b)
    );

    // Stand-in lab DUTs: s[1] is x, s[0] is y.
    function automatic logic dut_fn(input logic [2:0] code, input logic [1:0] s);
        case (code)
            3'd0:    dut_fn = s[1] & s[0];
            3'd1:    dut_fn = s[1] | s[0];
            3'd2:    dut_fn = s[1] ^ s[0];
            3'd3:    dut_fn = ~(s[1] & s[0]);
            3'd4:    dut_fn = s[1];
            3'd5:    dut_fn = s[0];
            3'd6:    dut_fn = 1'b0;
            default: dut_fn = 1'b1;
        endcase
    endfunction

    assign z_a = glitch_a ? 1'b0 : dut_fn(code_a, stim_a);
    assign z_b = dut_fn(code_b, stim_b);

    typedef struct {
        logic [2:0] code;
        logic [3:0] exp_tbl;
    } vec_t;

    vec_t       vecs[8];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string name, input logic [3:0] act);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0h with empty scoreboard", name, act);
        end else begin
            check(name, 32'(act), 32'(sb_q.pop_front()));
        end
    endtask

    // One complete run on dut_a, checking latency, table and handshake outputs.
    task automatic run_a(input logic [2:0] code, input logic [3:0] exp_tbl, input string name);
        int n;
        code_a = code;
        sb_q.push_back(exp_tbl);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check({name, " busy_after_start"}, 32'(busy_a), 32'd1);
        check({name, " valid_cleared"}, 32'(valid_a), 32'd0);
        check({name, " table_cleared"}, 32'(tbl_a), 32'd0);
        n = 0;
        while (!done_a && n < 100) begin
            tick();
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd13);
        pop_check({name, " table"}, tbl_a);
        check({name, " valid_at_done"}, 32'(valid_a), 32'd1);
        check({name, " busy_at_done"}, 32'(busy_a), 32'd0);
        check({name, " stim_idle"}, 32'(stim_a), 32'd0);
        tick();
        check({name, " done_single"}, 32'(done_a), 32'd0);
        check({name, " valid_hold"}, 32'(valid_a), 32'd1);
    endtask

    initial begin
        int n, t, first_done, ndone;
        int done_at[$];

        vecs[0] = '{3'd0, 4'b1000};
        vecs[1] = '{3'd1, 4'b1110};
        vecs[2] = '{3'd2, 4'b0110};
        vecs[3] = '{3'd3, 4'b0111};
        vecs[4] = '{3'd4, 4'b1100};
        vecs[5] = '{3'd5, 4'b1010};
        vecs[6] = '{3'd6, 4'b0000};
        vecs[7] = '{3'd7, 4'b1111};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; glitch_a = 1'b0;
        code_a = 3'd0; code_b = 3'd0;
`ifdef TT_COMPARE_EN
        exp_a = 4'd0; exp_b = 4'd0;
`endif
        tick();
        tick();
        check("reset stim", 32'(stim_a), 32'd0);
        check("reset table", 32'(tbl_a), 32'd0);
        check("reset busy", 32'(busy_a), 32'd0);
        check("reset done", 32'(done_a), 32'd0);
        check("reset valid", 32'(valid_a), 32'd0);
        check("reset b table", 32'(tbl_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_a(vecs[i].code, vecs[i].exp_tbl, $sformatf("vec%0d", i));
        end

        // XOR with three settle cycles: stim holds each value for 3 APPLY + 1 SAMPLE cycle.
        code_b = 3'd2;
        sb_q.push_back(4'b0110);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        t = 0;
        check("b stim t0", 32'(stim_b), 32'd0);
        while (!done_b && t < 100) begin
            tick();
            t++;
            if (t <= 15) begin
                check($sformatf("b stim t%0d", t), 32'(stim_b), 32'(t / 4));
            end
        end
        check("b latency", 32'(t), 32'd17);
        pop_check("b table", tbl_b);

        // start pulsed during APPLY of idx=1 must be ignored.
        code_a = 3'd0;
        sb_q.push_back(4'b1000);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0; first_done = -1; ndone = 0;
        while (n < 40) begin
            tick();
            n++;
            start_a = (n == 3);
            if (done_a) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = n;
                    pop_check("restart table", tbl_a);
                end
            end
        end
        check("restart latency", 32'(first_done), 32'd13);
        check("restart done count", 32'(ndone), 32'd1);

        // Asynchronous reset in the middle of SAMPLE of idx=2.
        code_a = 3'd3;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst table", 32'(tbl_a), 32'd0);
        check("async rst stim", 32'(stim_a), 32'd0);
        check("async rst busy", 32'(busy_a), 32'd0);
        check("async rst valid", 32'(valid_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_a(3'd3, 4'b0111, "post_reset");

        // OR with a settle-time glitch on stim=3, start held high for back-to-back runs.
        code_a = 3'd1;
        sb_q.push_back(4'b1110);
        sb_q.push_back(4'b1110);
        start_a = 1'b1;
        tick();
        n = 0;
        while (n < 45) begin
            tick();
            n++;
            glitch_a = (n == 9);
            if (n == 14) check("b2b valid drop", 32'(valid_a), 32'd0);
            if (n == 27) start_a = 1'b0;
            if (done_a) begin
                done_at.push_back(n);
                pop_check($sformatf("b2b table @%0d", n), tbl_a);
            end
        end
        glitch_a = 1'b0;
        check("b2b done count", 32'(done_at.size()), 32'd2);
        if (done_at.size() == 2) begin
            check("b2b first done", 32'(done_at[0]), 32'd13);
            check("b2b second done", 32'(done_at[1]), 32'd27);
        end

`ifdef TT_COMPARE_EN
        exp_a = 4'b1000;
        run_a(3'd0, 4'b1000, "cmp_match");
        check("mismatch low", 32'(mm_a), 32'd0);
        exp_a = 4'b1001;
        run_a(3'd0, 4'b1000, "cmp_diff");
        check("mismatch high", 32'(mm_a), 32'd1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("mismatch cleared", 32'(mm_a), 32'd0);
        n = 0;
        while (!done_a && n < 100) begin
            tick();
            n++;
        end
        check("cmp final latency", 32'(n), 32'd13);
`endif

        check("scoreboard empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
